ranged_bus_pipe: RTL and testbench

Parametrised successor to the two-bus pass-through model: a DEPTH-stage valid/ready register pipeline carrying two buses whose index ranges are set by parameters. Ranges may be descending, ascending or negative-indexed. The block sits between a producer and a consumer instance, in place of the direct bus0/bus1 wiring. Three routing modes are provided, including index-matched crossing between oppositely ordered buses, plus an occupancy count and a synchronous flush.

---
 rtl/ranged_bus_pipe.sv | 149 ++++++++++++++
 tb/tb_ranged_bus_pipe.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ranged_bus_pipe.sv
// ranged_bus_pipe: DEPTH-stage valid/ready register pipeline carrying two
// buses with parameterised (possibly ascending or negative) index ranges.
// Routing (straight, positional cross, index-matched cross) is applied
// before stage 0; the stages store routed data. Provides an occupancy
// count and a synchronous flush.
module ranged_bus_pipe #(
   parameter int          L0    = 2,
   parameter int          R0    = -2,
   parameter int          L1    = -2,
   parameter int          R1    = 2,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned MODE  = 0,
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [L0:R0]   i0,
   input  logic [L1:R1]   i1,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [L0:R0]   o0,
   output logic [L1:R1]   o1,
   output logic [CW-1:0]  count
);

   localparam int unsigned W0 = (L0 >= R0) ? 32'(L0 - R0 + 1) : 32'(R0 - L0 + 1);
   localparam int unsigned W1 = (L1 >= R1) ? 32'(L1 - R1 + 1) : 32'(R1 - L1 + 1);
   localparam int MIN0 = (L0 < R0) ? L0 : R0;
   localparam int MAX0 = (L0 < R0) ? R0 : L0;
   localparam int MIN1 = (L1 < R1) ? L1 : R1;
   localparam int MAX1 = (L1 < R1) ? R1 : L1;

   // Reject parameter combinations the datapath cannot represent.
   if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
      $error("ranged_bus_pipe: DEPTH must be in 1..16");
   end
   if (MODE > 2) begin : g_bad_mode
      $error("ranged_bus_pipe: MODE must be 0, 1 or 2");
   end
   if (MODE == 1 && W0 != W1) begin : g_bad_width
      $error("ranged_bus_pipe: MODE 1 needs equal bus widths");
   end

   // Routed payload presented to stage 0.
   logic [L0:R0] rt0;
   logic [L1:R1] rt1;

   // Input routing: index-matched cross zero-fills indices absent on the source bus.
   if (MODE == 2) begin : g_idx
      for (genvar k = MIN0; k <= MAX0; k++) begin : g_b0
         if (k >= MIN1 && k <= MAX1) begin : g_hit
            assign rt0[k] = i1[k];
         end else begin : g_zero
            assign rt0[k] = 1'b0;
         end
      end
      for (genvar k = MIN1; k <= MAX1; k++) begin : g_b1
         if (k >= MIN0 && k <= MAX0) begin : g_hit
            assign rt1[k] = i0[k];
         end else begin : g_zero
            assign rt1[k] = 1'b0;
         end
      end
   end else if (MODE == 1) begin : g_pos
      assign rt0 = i1;
      assign rt1 = i0;
   end else begin : g_str
      assign rt0 = i0;
      assign rt1 = i1;
   end

   // Bits of i0/i1 that a partial-overlap cross never reads.
   logic unused_bits;
   assign unused_bits = ^{i0, i1};

   logic [DEPTH-1:0] v_q, v_d;
   logic [L0:R0]     d0_q [DEPTH];
   logic [L0:R0]     d0_d [DEPTH];
   logic [L1:R1]     d1_q [DEPTH];
   logic [L1:R1]     d1_d [DEPTH];
   logic [CW-1:0]    count_q, count_d;
   logic [DEPTH-1:0] adv;

   // Advance chain from the output back to stage 0, and input handshake.
   always_comb begin
      logic chain;
      adv   = '0;
      chain = !v_q[DEPTH-1] || out_ready;
      adv[DEPTH-1] = chain;
      for (int s = int'(DEPTH) - 2; s >= 0; s--) begin
         chain  = !v_q[s] || chain;
         adv[s] = chain;
      end
      in_ready = adv[0] && !flush && !rst;
   end

   // Next-state: shift advancing stages, clear valids on flush, recount occupancy.
   always_comb begin
      v_d     = v_q;
      d0_d    = d0_q;
      d1_d    = d1_q;
      count_d = '0;
      if (flush) begin
         v_d = '0;
      end else begin
         if (adv[0]) begin
            v_d[0]  = in_valid && in_ready;
            d0_d[0] = rt0;
            d1_d[0] = rt1;
         end
         for (int s = 1; s < int'(DEPTH); s++) begin
            if (adv[s]) begin
               v_d[s]  = v_q[s-1];
               d0_d[s] = d0_q[s-1];
               d1_d[s] = d1_q[s-1];
            end
         end
      end
      for (int s = 0; s < int'(DEPTH); s++) begin
         count_d = count_d + CW'(v_d[s]);
      end
   end

   // Stage registers with synchronous reset that also clears data.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q     <= '0;
         count_q <= '0;
         for (int s = 0; s < int'(DEPTH); s++) begin
            d0_q[s] <= '0;
            d1_q[s] <= '0;
         end
      end else begin
         v_q     <= v_d;
         count_q <= count_d;
         d0_q    <= d0_d;
         d1_q    <= d1_d;
      end
   end

   assign out_valid = v_q[DEPTH-1];
   assign o0        = d0_q[DEPTH-1];
   assign o1        = d1_q[DEPTH-1];
   assign count     = count_q;

endmodule

// File: tb/tb_ranged_bus_pipe.sv
// Directed bench for ranged_bus_pipe: routing modes, flow, backpressure,
// flush and mid-stream reset across several parameterisations.
module tb_ranged_bus_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, flush, in_valid, out_ready;

   // Default-range buses shared by the MODE 0/1/2 instances.
   logic [2:-2] s_i0;
   logic [-2:2] s_i1;

   logic m0_ir, m0_ov; logic [2:-2] m0_o0; logic [-2:2] m0_o1; logic [1:0] m0_cnt;
   logic m1_ir, m1_ov; logic [2:-2] m1_o0; logic [-2:2] m1_o1; logic [1:0] m1_cnt;
   logic m2_ir, m2_ov; logic [2:-2] m2_o0; logic [-2:2] m2_o1; logic [1:0] m2_cnt;

   logic [3:0]  p_i0, p_o0;
   logic [1:-2] p_i1, p_o1;
   logic p_ir, p_ov; logic [1:0] p_cnt;

   logic [7:0] d_i0, d_o0;
   logic [0:7] d_i1, d_o1;
   logic d_ir, d_ov; logic [2:0] d_cnt;

   ranged_bus_pipe #(.MODE(0)) u_m0 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(m0_ir),
      .i0(s_i0), .i1(s_i1), .out_valid(m0_ov), .out_ready(out_ready),
      .o0(m0_o0), .o1(m0_o1), .count(m0_cnt));

   ranged_bus_pipe #(.MODE(1)) u_m1 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(m1_ir),
      .i0(s_i0), .i1(s_i1), .out_valid(m1_ov), .out_ready(out_ready),
      .o0(m1_o0), .o1(m1_o1), .count(m1_cnt));

   ranged_bus_pipe #(.MODE(2)) u_m2 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(m2_ir),
      .i0(s_i0), .i1(s_i1), .out_valid(m2_ov), .out_ready(out_ready),
      .o0(m2_o0), .o1(m2_o1), .count(m2_cnt));

   ranged_bus_pipe #(.L0(3), .R0(0), .L1(1), .R1(-2), .MODE(2)) u_p2 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(p_ir),
      .i0(p_i0), .i1(p_i1), .out_valid(p_ov), .out_ready(out_ready),
      .o0(p_o0), .o1(p_o1), .count(p_cnt));

   ranged_bus_pipe #(.L0(7), .R0(0), .L1(0), .R1(7), .DEPTH(4), .MODE(0)) u_d4 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d_ir),
      .i0(d_i0), .i1(d_i1), .out_valid(d_ov), .out_ready(out_ready),
      .o0(d_o0), .o1(d_o1), .count(d_cnt));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [4:0] i0, i1;
      logic [4:0] m1o0, m1o1, m2o0, m2o1;
      logic [3:0] pi0, pi1, po0, po1;
   } vec_t;

   vec_t tbl[4];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent, recv, seen;

      tbl[0] = '{i0:5'b10110, i1:5'b00011, m1o0:5'b00011, m1o1:5'b10110,
                 m2o0:5'b11000, m2o1:5'b01101,
                 pi0:4'b1010, pi1:4'b1111, po0:4'b0011, po1:4'b1000};
      tbl[1] = '{i0:5'b00001, i1:5'b10000, m1o0:5'b10000, m1o1:5'b00001,
                 m2o0:5'b00001, m2o1:5'b10000,
                 pi0:4'b0111, pi1:4'b0100, po0:4'b0001, po1:4'b1100};
      tbl[2] = '{i0:5'b11100, i1:5'b01010, m1o0:5'b01010, m1o1:5'b11100,
                 m2o0:5'b01010, m2o1:5'b00111,
                 pi0:4'b1001, pi1:4'b1000, po0:4'b0010, po1:4'b0100};
      tbl[3] = '{i0:5'b11111, i1:5'b00000, m1o0:5'b00000, m1o1:5'b11111,
                 m2o0:5'b00000, m2o1:5'b11111,
                 pi0:4'b0000, pi1:4'b0011, po0:4'b0000, po1:4'b0000};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      s_i0 = '0; s_i1 = '0; p_i0 = '0; p_i1 = '0; d_i0 = '0; d_i1 = '0;

      // Reset state
      @(negedge clk); @(negedge clk);
      chk("rst_in_ready", m0_ir, 0);
      chk("rst_out_valid", m0_ov, 0);
      chk("rst_count", m0_cnt, 0);
      chk("rst_o0", m0_o0, 0);
      chk("rst_o1", m0_o1, 0);
      chk("rst_m2_o0", m2_o0, 0);
      chk("rst_d4_count", d_cnt, 0);
      rst = 1'b0;
      #1 chk("in_ready_after_rst", m0_ir, 1);

      // Basic flow on defaults: two beats, count 1,2,1
      s_i0 = 5'b10110; s_i1 = 5'b00011; in_valid = 1'b1;
      @(negedge clk);
      chk("flow_count1", m0_cnt, 1);
      chk("flow_ov_early", m0_ov, 0);
      s_i0 = 5'b01001; s_i1 = 5'b11100;
      @(negedge clk);
      chk("flow_count2", m0_cnt, 2);
      chk("flow_ov", m0_ov, 1);
      chk("flow_o0", m0_o0, 5'b10110);
      chk("flow_o1", m0_o1, 5'b00011);
      chk("flow_m2_o0", m2_o0, 5'b11000);
      chk("flow_m2_o1", m2_o1, 5'b01101);
      chk("flow_m1_o0", m1_o0, 5'b00011);
      chk("flow_m1_o1", m1_o1, 5'b10110);
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("flow_count3", m0_cnt, 1);
      chk("flow_o0_b", m0_o0, 5'b01001);
      chk("flow_o1_b", m0_o1, 5'b11100);
      @(negedge clk);
      chk("flow_drained_ov", m0_ov, 0);
      chk("flow_drained_cnt", m0_cnt, 0);
      out_ready = 1'b0;

      // Routing table: one beat per vector through every DEPTH-2 instance
      for (int t = 0; t < 4; t++) begin
         s_i0 = tbl[t].i0; s_i1 = tbl[t].i1;
         p_i0 = tbl[t].pi0; p_i1 = tbl[t].pi1;
         in_valid = 1'b1;
         #1;
         chk($sformatf("vec%0d_m0_ir", t), m0_ir, 1);
         chk($sformatf("vec%0d_m1_ir", t), m1_ir, 1);
         chk($sformatf("vec%0d_m2_ir", t), m2_ir, 1);
         chk($sformatf("vec%0d_p_ir", t), p_ir, 1);
         @(negedge clk);
         in_valid = 1'b0;
         @(negedge clk);
         chk($sformatf("vec%0d_m0_ov", t), m0_ov, 1);
         chk($sformatf("vec%0d_m0_o0", t), m0_o0, tbl[t].i0);
         chk($sformatf("vec%0d_m0_o1", t), m0_o1, tbl[t].i1);
         chk($sformatf("vec%0d_m1_ov", t), m1_ov, 1);
         chk($sformatf("vec%0d_m1_cnt", t), m1_cnt, 1);
         chk($sformatf("vec%0d_m1_o0", t), m1_o0, tbl[t].m1o0);
         chk($sformatf("vec%0d_m1_o1", t), m1_o1, tbl[t].m1o1);
         chk($sformatf("vec%0d_m2_ov", t), m2_ov, 1);
         chk($sformatf("vec%0d_m2_cnt", t), m2_cnt, 1);
         chk($sformatf("vec%0d_m2_o0", t), m2_o0, tbl[t].m2o0);
         chk($sformatf("vec%0d_m2_o1", t), m2_o1, tbl[t].m2o1);
         chk($sformatf("vec%0d_p_ov", t), p_ov, 1);
         chk($sformatf("vec%0d_p_cnt", t), p_cnt, 1);
         chk($sformatf("vec%0d_p_o0", t), p_o0, tbl[t].po0);
         chk($sformatf("vec%0d_p_o1", t), p_o1, tbl[t].po1);
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
      end

      // Backpressure on DEPTH 4
      rst = 1'b1; in_valid = 1'b0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      sent = 0; recv = 0;
      for (int c = 0; c < 6; c++) begin
         d_i0 = 8'(sent); d_i1 = 8'(sent) ^ 8'h5A; in_valid = 1'b1;
         #1;
         if (d_ir) sent++;
         @(negedge clk);
      end
      chk("bp_accepts", 32'(sent), 4);
      chk("bp_count_full", d_cnt, 4);
      chk("bp_in_ready_full", d_ir, 0);
      chk("bp_ov_held", d_ov, 1);
      chk("bp_o0_held", d_o0, 8'h00);
      out_ready = 1'b1;
      for (int c = 0; c < 40 && recv < 10; c++) begin
         chk($sformatf("bp_no_gap%0d", c), d_ov, 1);
         if (sent < 10) chk($sformatf("bp_count_stays%0d", c), d_cnt, 4);
         if (d_ov) begin
            chk($sformatf("bp_o0_beat%0d", recv), d_o0, 8'(recv));
            chk($sformatf("bp_o1_beat%0d", recv), d_o1, 8'(recv) ^ 8'h5A);
            recv++;
         end
         if (sent < 10) begin
            d_i0 = 8'(sent); d_i1 = 8'(sent) ^ 8'h5A; in_valid = 1'b1;
            #1;
            chk($sformatf("bp_full_rate%0d", c), d_ir, 1);
            if (d_ir) sent++;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      chk("bp_received", 32'(recv), 10);
      chk("bp_no_extra", d_ov, 0);
      chk("bp_empty_count", d_cnt, 0);

      // Flush with 3 of 4 stages valid and the head beat on the output
      out_ready = 1'b0; in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         d_i0 = 8'h20 + 8'(k); d_i1 = 8'h28 + 8'(k); in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("fl_pre_count", d_cnt, 3);
      chk("fl_pre_ov", d_ov, 1);
      chk("fl_pre_o0", d_o0, 8'h20);
      flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      d_i0 = 8'h30; d_i1 = 8'h31;
      #1 chk("fl_blocks_accept", d_ir, 0);
      @(negedge clk);
      flush = 1'b0;
      chk("fl_count_zero", d_cnt, 0);
      chk("fl_ov_zero", d_ov, 0);
      #1 chk("fl_ready_again", d_ir, 1);
      @(negedge clk);
      in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("fl_latency%0d", c), d_ov, 0);
         @(negedge clk);
      end
      chk("fl_fresh_ov", d_ov, 1);
      chk("fl_fresh_o0", d_o0, 8'h30);
      chk("fl_fresh_o1", d_o1, 8'h31);
      @(negedge clk);
      chk("fl_only_fresh", d_ov, 0);

      // Reset in the middle of a flowing stream
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         d_i0 = 8'h40 + 8'(c); d_i1 = 8'h50 + 8'(c); in_valid = 1'b1;
         @(negedge clk);
      end
      chk("mr_pre_ov", d_ov, 1);
      rst = 1'b1;
      #1 chk("mr_in_ready_low", d_ir, 0);
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      chk("mr_ov", d_ov, 0);
      chk("mr_count", d_cnt, 0);
      chk("mr_o0", d_o0, 0);
      chk("mr_o1", d_o1, 0);
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         if (d_ov) seen++;
         @(negedge clk);
      end
      chk("mr_no_stale_beats", 32'(seen), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
